// File: rtl/uart_dump_tx.sv
// UART memory-readback transmitter: reads a word range from program ROM or
// data memory and sends each word as four little-endian 8N1 frames.
module uart_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned ADR_W        = 15
) (
  input  logic             upg_clk_i,
  input  logic             upg_rstn_i,
  input  logic             dump_start_i,
  input  logic [ADR_W-1:0] dump_base_i,
  input  logic [ADR_W-1:0] dump_len_i,
  output logic             mem_rd_o,
  output logic [ADR_W-1:0] mem_adr_o,
  input  logic [31:0]      mem_dat_i,
  output logic             upg_tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StSend, StFinish} state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_clk_cnt;
  logic [3:0]       r_bit_idx;
  logic [1:0]       r_byte_idx;
  logic [31:0]      r_shift;
  logic [ADR_W-1:0] r_cur_adr;
  logic [ADR_W-1:0] r_remain;
  logic [ADR_W-1:0] r_mem_adr;
  logic             r_mem_rd;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_zero_pend;

  // Only the low bits advance; the MSB memory select is carried through unchanged.
  logic [ADR_W-1:0] w_next_adr;
  assign w_next_adr = {r_cur_adr[ADR_W-1], r_cur_adr[ADR_W-2:0] + (ADR_W-1)'(1)};

  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      r_state     <= StIdle;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_cur_adr   <= '0;
      r_remain    <= '0;
      r_mem_adr   <= '0;
      r_mem_rd    <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_zero_pend <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // A zero-length request completes one cycle after it is sampled.
          r_done      <= r_zero_pend;
          r_zero_pend <= 1'b0;
          if (dump_start_i) begin
            if (dump_len_i != '0) begin
              r_cur_adr <= dump_base_i;
              r_mem_adr <= dump_base_i;
              r_remain  <= dump_len_i;
              r_mem_rd  <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= StRead;
            end else begin
              r_zero_pend <= 1'b1;
            end
          end
        end
        StRead: begin
          r_state <= StWait;
        end
        StWait: begin
          r_shift    <= mem_dat_i;
          r_tx       <= 1'b0;
          r_clk_cnt  <= '0;
          r_bit_idx  <= '0;
          r_byte_idx <= '0;
          r_state    <= StSend;
        end
        StSend: begin
          if (r_clk_cnt != LastCnt) begin
            r_clk_cnt <= r_clk_cnt + CntW'(1);
          end else begin
            r_clk_cnt <= '0;
            if (r_bit_idx != 4'd9) begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_tx      <= (r_bit_idx < 4'd8) ? r_shift[r_bit_idx[2:0]] : 1'b1;
            end else if (r_byte_idx != 2'd3) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_bit_idx  <= '0;
              r_tx       <= 1'b0;
              r_shift    <= r_shift >> 8;
            end else begin
              r_remain  <= r_remain - ADR_W'(1);
              r_cur_adr <= w_next_adr;
              r_tx      <= 1'b1;
              if (r_remain != ADR_W'(1)) begin
                r_mem_adr <= w_next_adr;
                r_mem_rd  <= 1'b1;
                r_state   <= StRead;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StFinish;
              end
            end
          end
        end
        StFinish: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign mem_rd_o  = r_mem_rd;
  assign mem_adr_o = r_mem_adr;
  assign upg_tx_o  = r_tx;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule

// File: tb/tb_uart_dump_tx.sv
// Randomized bench for uart_dump_tx: a word-level model predicts the line
// waveform, read addresses, busy/done timing and the decoded byte stream.
module tb_uart_dump_tx;

  localparam int Cpb    = 4;
  localparam int FrameK = 10 * Cpb;
  localparam int WordK  = 4 * FrameK;
  localparam int StrideK = WordK + 2;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [14:0] base;
  logic [14:0] len;
  logic        mem_rd;
  logic [14:0] mem_adr;
  logic [31:0] mem_dat;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:32767];

  int n_cmp;
  int n_err;

  uart_dump_tx #(
    .CLKS_PER_BIT(Cpb),
    .ADR_W       (15)
  ) dut (
    .upg_clk_i   (clk),
    .upg_rstn_i  (rstn),
    .dump_start_i(start),
    .dump_base_i (base),
    .dump_len_i  (len),
    .mem_rd_o    (mem_rd),
    .mem_adr_o   (mem_adr),
    .mem_dat_i   (mem_dat),
    .upg_tx_o    (tx),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM.
  always @(posedge clk) begin
    if (mem_rd) mem_dat <= mem[mem_adr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] exp_adr(input logic [14:0] b, input int i);
    int a;
    a = (int'(b) & 32'h4000) | ((int'(b) + i) & 32'h3FFF);
    return a[14:0];
  endfunction

  task automatic run_dump(input string name, input logic [14:0] b, input logic [14:0] l,
                          input int inj_k, input logic [14:0] inj_base);
    logic [7:0]  exp_b[$];
    logic [7:0]  got_b[$];
    int          exp_st[$];
    int          got_st[$];
    logic        txs[$];
    int          rd_k[$];
    logic [14:0] rd_a[$];
    logic [31:0] w;
    logic [7:0]  cur;
    logic        e;
    logic        exp_busy;
    int n, done_k, kmax, done_seen, done_cnt, busy_err, tx_err;
    int wi, t, by, bt;

    n = int'(l);
    for (int i = 0; i < n; i++) begin
      w = mem[exp_adr(b, i)];
      for (int j = 0; j < 4; j++) begin
        exp_b.push_back(w[8*j +: 8]);
        exp_st.push_back(2 + i * StrideK + j * FrameK);
      end
    end
    done_k    = (n == 0) ? 1 : 2 + n * WordK + (n - 1) * 2;
    kmax      = done_k + 4;
    done_seen = -1;
    done_cnt  = 0;
    busy_err  = 0;
    tx_err    = 0;

    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == inj_k) begin
          start = 1'b1;
          base  = inj_base;
          len   = 15'd1;
        end else if (k == inj_k + 1) begin
          start = 1'b0;
        end
      end
      txs.push_back(tx);
      if (mem_rd) begin
        rd_k.push_back(k);
        rd_a.push_back(mem_adr);
      end
      if (done) begin
        done_cnt++;
        if (done_seen < 0) done_seen = k;
      end
      exp_busy = (n != 0) && (k < done_k);
      if (busy !== exp_busy) busy_err++;
      e = 1'b1;
      if (k >= 2) begin
        wi = (k - 2) / StrideK;
        t  = (k - 2) % StrideK;
        if (wi < n && t < WordK) begin
          by = t / FrameK;
          bt = (t % FrameK) / Cpb;
          if (bt == 0) e = 1'b0;
          else if (bt == 9) e = 1'b1;
          else begin
            cur = exp_b[wi * 4 + by];
            e   = cur[bt - 1];
          end
        end
      end
      if (tx !== e) tx_err++;
    end

    check_eq({name, ".done_at"}, done_seen, done_k);
    check_eq({name, ".done_cnt"}, done_cnt, 1);
    check_eq({name, ".busy_errs"}, busy_err, 0);
    check_eq({name, ".tx_wave_errs"}, tx_err, 0);
    check_eq({name, ".rd_cnt"}, rd_k.size(), n);
    for (int i = 0; i < n && i < rd_k.size(); i++) begin
      check_eq($sformatf("%s.rd_k%0d", name, i), rd_k[i], i * StrideK);
      check_eq($sformatf("%s.rd_adr%0d", name, i), rd_a[i], exp_adr(b, i));
    end

    // Independent UART receiver: find start bits, sample mid-bit.
    for (int k = 0; k + FrameK <= txs.size(); k++) begin
      if (txs[k] == 1'b0) begin
        for (int j = 0; j < 8; j++) cur[j] = txs[k + Cpb * (j + 1) + Cpb / 2];
        check_eq($sformatf("%s.stop%0d", name, got_b.size()), txs[k + 9 * Cpb + Cpb / 2], 1);
        got_b.push_back(cur);
        got_st.push_back(k);
        k += FrameK - 1;
      end
    end
    check_eq({name, ".byte_cnt"}, got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      check_eq($sformatf("%s.byte%0d", name, i), got_b[i], exp_b[i]);
      check_eq($sformatf("%s.start%0d", name, i), got_st[i], exp_st[i]);
    end
  endtask

  initial begin
    logic [14:0] rb;
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rstn  = 1'b1;
    start = 1'b0;
    base  = '0;
    len   = '0;
    for (int i = 0; i < 32768; i++) mem[i] = $urandom;

    #1 rstn = 1'b0;
    #1;
    check_eq("reset.tx", tx, 1);
    check_eq("reset.busy", busy, 0);
    check_eq("reset.done", done, 0);
    check_eq("reset.rd", mem_rd, 0);
    check_eq("reset.adr", mem_adr, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    mem[15'h0000] = 32'h12345678;
    run_dump("single", 15'h0000, 15'd1, -1, 15'h0);
    mem[15'h4000] = 32'hA5A5A5A5;
    mem[15'h4001] = 32'h000000FF;
    run_dump("dmem", 15'h4000, 15'd2, -1, 15'h0);
    run_dump("wrap_dmem", 15'h7FFF, 15'd2, -1, 15'h0);
    run_dump("wrap_prom", 15'h3FFF, 15'd2, -1, 15'h0);
    run_dump("zero", 15'($urandom), 15'd0, -1, 15'h0);
    run_dump("busy_start", 15'h0100, 15'd2, 2 + FrameK + 10, 15'h2222);
    for (int r = 0; r < 6; r++) begin
      run_dump($sformatf("rand%0d", r), 15'($urandom), 15'($urandom_range(1, 3)), -1, 15'h0);
    end

    // Reset during the data bits of byte 2, with byte 2 forced to zero.
    rb = 15'($urandom);
    mem[rb] = $urandom & 32'hFF00FFFF;
    @(posedge clk); #1;
    start = 1'b1;
    base  = rb;
    len   = 15'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 2 + 2 * FrameK + 3 * Cpb + 1; k++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_mid.pre_tx", tx, 0);
    check_eq("rst_mid.pre_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_mid.tx", tx, 1);
    check_eq("rst_mid.busy", busy, 0);
    check_eq("rst_mid.rd", mem_rd, 0);
    check_eq("rst_mid.done", done, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run_dump("after_rst", rb, 15'd2, -1, 15'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
